// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC burst transfer engine.
// Holds the sequencer state encoding, the idle value of the
// multiplexed address/data bus, the legal parameter ranges and a
// small helper used to size the phase timer.
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_A_AS,
        S_A_CS,
        S_A_STB,
        S_A_END,
        S_A_REL,
        S_D_CS,
        S_D_STB,
        S_D_END,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [7:0] BUS_IDLE = 8'hFF;

    localparam int unsigned N_REGS_MIN = 1;
    localparam int unsigned N_REGS_MAX = 8;
    localparam int unsigned T_MIN      = 1;
    localparam int unsigned T_MAX      = 255;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter used to time the address strobe, data strobe
// and inter-entry gap phases.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   load         : load load_val on the next edge (takes priority)
//   load_val     : number of remaining cycles minus one
//   zero         : counter has reached zero (last cycle of the phase)
// The counter saturates at zero and never wraps.
module rtc_phase_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rtc_burst_xfer.sv
// RTC burst transfer engine. On a rising edge of start it walks a
// table of up to N_REGS register accesses in ascending index order,
// running each enabled entry as an address phase followed by a write
// or read data phase on a multiplexed 8-bit bus.
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   start          : burst request level, launches on a rising edge
//   en_mask        : per-entry enable
//   rw_mask        : per-entry direction, 1 = write, 0 = read
//   addr_tbl       : per-entry register address, entry i in [8i+7:8i]
//   wdata_tbl      : per-entry write data
//   ad_in          : sampled bus value
//   ad_out, ad_oe  : driven bus value and drive enable
//   as_n, cs_n     : active-low address strobe and chip select
//   wr_n, rd_n     : active-low write and read strobes
//   rdata_tbl      : read results, entry i updated only by a read of i
//   busy           : high from launch until done
//   done           : one-cycle pulse at burst end
module rtc_burst_xfer
    import rtc_bus_pkg::*;
#(
    parameter int unsigned N_REGS = 5,
    parameter int unsigned T_ADDR = 6,
    parameter int unsigned T_DATA = 6,
    parameter int unsigned T_GAP  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N_REGS-1:0]     en_mask,
    input  logic [N_REGS-1:0]     rw_mask,
    input  logic [8*N_REGS-1:0]   addr_tbl,
    input  logic [8*N_REGS-1:0]   wdata_tbl,
    input  logic [7:0]            ad_in,
    output logic [7:0]            ad_out,
    output logic                  ad_oe,
    output logic                  as_n,
    output logic                  cs_n,
    output logic                  wr_n,
    output logic                  rd_n,
    output logic [8*N_REGS-1:0]   rdata_tbl,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned T_LONGEST = max3(T_ADDR, T_DATA, T_GAP);
    localparam int unsigned TW        = $clog2(T_LONGEST + 1);
    localparam int unsigned IW        = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    if (N_REGS < N_REGS_MIN || N_REGS > N_REGS_MAX ||
        T_ADDR < T_MIN || T_ADDR > T_MAX ||
        T_DATA < T_MIN || T_DATA > T_MAX ||
        T_GAP  < T_MIN || T_GAP  > T_MAX) begin : g_param_err
        $error("rtc_burst_xfer: parameter out of range");
    end

    state_t          state;
    state_t          state_nx;
    logic            start_q;
    logic            launch;
    logic [N_REGS-1:0] pend_q;
    logic [N_REGS-1:0] rw_q;
    logic [7:0]      addr_q  [N_REGS];
    logic [7:0]      wdata_q [N_REGS];
    logic [7:0]      rdata_q [N_REGS];
    logic [IW-1:0]   cur;
    logic [IW-1:0]   first;
    logic            found;

    logic            t_load;
    logic [TW-1:0]   t_val;
    logic            t_zero;

    logic [7:0]      ad_out_nx;
    logic            ad_oe_nx;
    logic            as_n_nx;
    logic            cs_n_nx;
    logic            wr_n_nx;
    logic            rd_n_nx;
    logic            busy_nx;
    logic            done_nx;

    // A new burst may also launch straight out of DONE, since busy is
    // already low on that cycle.
    assign launch = start && !start_q &&
                    (state == S_IDLE || state == S_DONE);

    // Lowest still-pending enabled entry.
    always_comb begin
        first = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (pend_q[i] && !found) begin
                first = IW'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (launch) state_nx = S_SCAN;
            S_SCAN:  state_nx = found ? S_A_AS : S_DONE;
            S_A_AS:  state_nx = S_A_CS;
            S_A_CS:  state_nx = S_A_STB;
            S_A_STB: if (t_zero) state_nx = S_A_END;
            S_A_END: state_nx = S_A_REL;
            S_A_REL: state_nx = S_D_CS;
            S_D_CS:  state_nx = S_D_STB;
            S_D_STB: if (t_zero) state_nx = S_D_END;
            S_D_END: state_nx = S_GAP;
            S_GAP:   if (t_zero) state_nx = S_SCAN;
            S_DONE:  state_nx = launch ? S_SCAN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The timer is loaded on entry to each timed phase with length-1,
    // so its zero flag marks the final cycle of that phase.
    always_comb begin
        t_load = (state_nx != state) &&
                 (state_nx inside {S_A_STB, S_D_STB, S_GAP});
        case (state_nx)
            S_A_STB: t_val = TW'(T_ADDR - 1);
            S_D_STB: t_val = TW'(T_DATA - 1);
            default: t_val = TW'(T_GAP - 1);
        endcase
    end

    rtc_phase_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    // Bus pins are decoded from the next state and registered, so they
    // change on the same edge as the state register. cur is already
    // stable by the time any phase that drives address or data begins.
    always_comb begin
        ad_out_nx = BUS_IDLE;
        ad_oe_nx  = 1'b0;
        as_n_nx   = 1'b1;
        cs_n_nx   = 1'b1;
        wr_n_nx   = 1'b1;
        rd_n_nx   = 1'b1;
        busy_nx   = 1'b1;
        done_nx   = 1'b0;
        case (state_nx)
            S_IDLE: busy_nx = 1'b0;
            S_A_AS: as_n_nx = 1'b0;
            S_A_CS: begin
                as_n_nx = 1'b0;
                cs_n_nx = 1'b0;
            end
            S_A_STB: begin
                as_n_nx   = 1'b0;
                cs_n_nx   = 1'b0;
                wr_n_nx   = 1'b0;
                ad_oe_nx  = 1'b1;
                ad_out_nx = addr_q[cur];
            end
            S_A_END: begin
                as_n_nx   = 1'b0;
                ad_oe_nx  = 1'b1;
                ad_out_nx = addr_q[cur];
            end
            S_D_CS: cs_n_nx = 1'b0;
            S_D_STB: begin
                cs_n_nx = 1'b0;
                if (rw_q[cur]) begin
                    wr_n_nx   = 1'b0;
                    ad_oe_nx  = 1'b1;
                    ad_out_nx = wdata_q[cur];
                end else begin
                    rd_n_nx = 1'b0;
                end
            end
            S_DONE: begin
                busy_nx = 1'b0;
                done_nx = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
            pend_q  <= '0;
            rw_q    <= '0;
            cur     <= '0;
            ad_out  <= BUS_IDLE;
            ad_oe   <= 1'b0;
            as_n    <= 1'b1;
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            rd_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int unsigned i = 0; i < N_REGS; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            start_q <= start;
            state   <= state_nx;
            ad_out  <= ad_out_nx;
            ad_oe   <= ad_oe_nx;
            as_n    <= as_n_nx;
            cs_n    <= cs_n_nx;
            wr_n    <= wr_n_nx;
            rd_n    <= rd_n_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            if (launch) begin
                pend_q <= en_mask;
                rw_q   <= rw_mask;
            end
            if (state == S_SCAN && found) begin
                cur           <= first;
                pend_q[first] <= 1'b0;
            end
            if (state == S_D_STB && t_zero && !rw_q[cur]) begin
                rdata_q[cur] <= ad_in;
            end
        end
    end

    // Address and data tables are only consumed after a launch, so they
    // need no reset.
    always_ff @(posedge clock) begin
        if (launch) begin
            for (int unsigned i = 0; i < N_REGS; i++) begin
                addr_q[i]  <= addr_tbl[8*i +: 8];
                wdata_q[i] <= wdata_tbl[8*i +: 8];
            end
        end
    end

    for (genvar g = 0; g < int'(N_REGS); g++) begin : g_rdata
        assign rdata_tbl[8*g +: 8] = rdata_q[g];
    end

endmodule

// File: tb/tb_rtc_burst_xfer.sv
// Self-checking bench for rtc_burst_xfer with default parameters.
// Stimulus pushes expected bus transactions and burst latencies into
// queues; a monitor watches the bus, pops and compares.
module tb_rtc_burst_xfer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  en_mask = '0;
    logic [4:0]  rw_mask = '0;
    logic [39:0] addr_tbl = '0;
    logic [39:0] wdata_tbl = '0;
    logic [7:0]  ad_in;
    logic [7:0]  ad_out;
    logic        ad_oe, as_n, cs_n, wr_n, rd_n, busy, done;
    logic [39:0] rdata_tbl;

    always #5 clock = ~clock;

    rtc_burst_xfer #(
        .N_REGS (5),
        .T_ADDR (6),
        .T_DATA (6),
        .T_GAP  (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .en_mask   (en_mask),
        .rw_mask   (rw_mask),
        .addr_tbl  (addr_tbl),
        .wdata_tbl (wdata_tbl),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .as_n      (as_n),
        .cs_n      (cs_n),
        .wr_n      (wr_n),
        .rd_n      (rd_n),
        .rdata_tbl (rdata_tbl),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    txn_t       txn_q[$];
    int         lat_q[$];
    logic [7:0] bus_mem [256];
    logic [7:0] exp_rdata [5];
    logic [7:0] cur_addr = '0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         strobe_cycles = 0;

    // Bus slave model: returns the stored byte for the last address.
    assign ad_in = (rd_n == 1'b0) ? bus_mem[cur_addr] : 8'h00;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_rdata();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rdata[%0d]", i), 64'(rdata_tbl[8*i +: 8]),
                  64'(exp_rdata[i]));
        end
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_ad_out"}, 64'(ad_out), 64'hFF);
        check({tag, "_ad_oe"},  64'(ad_oe), 0);
        check({tag, "_strobes"}, 64'({as_n, cs_n, wr_n, rd_n}), 64'hF);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
    endtask

    // Monitor: bus protocol every cycle, transaction and latency scoreboard.
    initial begin : monitor
        int         cyc;
        int         addr_w;
        int         data_w;
        bit         in_data;
        bit         prev_busy;
        bit         cur_rw;
        logic [7:0] cur_data;
        txn_t       e;
        cyc = 0; addr_w = 0; data_w = 0;
        in_data = 0; prev_busy = 0; cur_rw = 0; cur_data = '0;
        forever begin
            @(negedge clock);
            check("wr_rd_overlap", 64'(wr_n | rd_n), 1);
            check("oe_during_read", 64'(!rd_n && ad_oe), 0);
            check("ad_out_idle", 64'(!ad_oe && ad_out != 8'hFF), 0);
            if (!as_n || !cs_n || !wr_n || !rd_n) strobe_cycles++;
            if (busy && !prev_busy) cyc = 1;
            else cyc++;
            prev_busy = busy;
            if (reset) begin
                in_data = 0; addr_w = 0; data_w = 0;
            end else if (!as_n && !wr_n) begin
                cur_addr = ad_out;
                addr_w++;
            end else if (as_n && (!wr_n || !rd_n)) begin
                in_data  = 1;
                data_w++;
                cur_rw   = !wr_n;
                cur_data = !wr_n ? ad_out : ad_in;
            end else if (in_data && wr_n && rd_n) begin
                check("txn_expected", 64'(txn_q.size() != 0), 1);
                if (txn_q.size() != 0) begin
                    e = txn_q.pop_front();
                    check("txn_rw", 64'(cur_rw), 64'(e.rw));
                    check("txn_addr", 64'(cur_addr), 64'(e.addr));
                    if (e.rw) check("txn_wdata", 64'(cur_data), 64'(e.data));
                    check("addr_strobe_width", 64'(addr_w), 6);
                    check("data_strobe_width", 64'(data_w), 6);
                end
                if (cur_rw) bus_mem[cur_addr] = cur_data;
                in_data = 0; addr_w = 0; data_w = 0;
            end
            if (done) begin
                done_cnt++;
                check("done_expected", 64'(lat_q.size() != 0), 1);
                if (lat_q.size() != 0) begin
                    check("burst_latency", 64'(cyc), 64'(lat_q.pop_front()));
                end
                check("txn_left_at_done", 64'(txn_q.size()), 0);
            end
        end
    end

    task automatic wait_done(input int c0);
        int k;
        k = 0;
        while (done_cnt == c0 && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check("done_timeout", 64'(done_cnt != c0), 1);
    endtask

    task automatic setup(input logic [4:0] en, input logic [4:0] rw,
                         input logic [39:0] at, input logic [39:0] wt);
        en_mask   = en;
        rw_mask   = rw;
        addr_tbl  = at;
        wdata_tbl = wt;
        for (int i = 0; i < 5; i++) begin
            if (en[i]) txn_q.push_back({rw[i], at[8*i +: 8], wt[8*i +: 8]});
        end
    endtask

    task automatic run_burst(input logic [4:0] en, input logic [4:0] rw,
                             input logic [39:0] at, input logic [39:0] wt,
                             input int lat);
        int c0;
        setup(en, rw, at, wt);
        lat_q.push_back(lat);
        c0 = done_cnt;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(c0);
        repeat (2) @(negedge clock);
    endtask

    initial begin : stimulus
        int c0;
        int s0;
        int k;
        for (int i = 0; i < 256; i++) bus_mem[i] = 8'h00;
        for (int i = 0; i < 5; i++) exp_rdata[i] = 8'h00;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_idle_bus("reset");
        check_rdata();

        // Read all five entries to give every slot a known value.
        bus_mem[8'h30] = 8'h11; bus_mem[8'h31] = 8'h22; bus_mem[8'h32] = 8'h33;
        bus_mem[8'h33] = 8'h44; bus_mem[8'h34] = 8'h55;
        run_burst(5'h1F, 5'h00, 40'h34_33_32_31_30, 40'h0, 137);
        exp_rdata[0] = 8'h11; exp_rdata[1] = 8'h22; exp_rdata[2] = 8'h33;
        exp_rdata[3] = 8'h44; exp_rdata[4] = 8'h55;
        check_rdata();

        // Five writes in order; read slots untouched.
        run_burst(5'h1F, 5'h1F, 40'hF1_00_21_22_23, 40'hA4_A3_A2_A1_A0, 137);
        check_rdata();
        check_idle_bus("after_writes");

        // Sparse read: entries 0 and 2 only.
        bus_mem[8'h10] = 8'h45; bus_mem[8'h12] = 8'h30;
        run_burst(5'b00101, 5'h00, 40'h14_13_12_11_10, 40'h0, 56);
        exp_rdata[0] = 8'h45; exp_rdata[2] = 8'h30;
        check_rdata();

        // Empty burst.
        s0 = strobe_cycles;
        run_burst(5'h00, 5'h00, 40'h0, 40'h0, 2);
        check("empty_no_strobes", 64'(strobe_cycles), 64'(s0));

        // Start held across done with a second edge while busy.
        setup(5'b00001, 5'b00001, 40'h60, 40'h5A);
        lat_q.push_back(29);
        c0 = done_cnt;
        start = 1'b1;
        repeat (5) @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1;
        wait_done(c0);
        repeat (40) @(negedge clock);
        check("single_burst", 64'(done_cnt - c0), 1);
        start = 1'b0;
        repeat (2) @(negedge clock);

        // Reset during the data strobe of entry 1 (a read).
        setup(5'b00001, 5'b00001, 40'h51_50, 40'h00_77);
        en_mask = 5'b00011;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (rd_n != 1'b0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        check("reach_read_strobe", 64'(rd_n), 0);
        reset = 1'b1;
        @(negedge clock);
        check_idle_bus("mid_reset");
        for (int i = 0; i < 5; i++) exp_rdata[i] = 8'h00;
        check_rdata();
        @(negedge clock);
        reset = 1'b0;
        s0 = strobe_cycles;
        c0 = done_cnt;
        repeat (60) @(negedge clock);
        check("no_strobes_after_reset", 64'(strobe_cycles), 64'(s0));
        check("no_done_after_reset", 64'(done_cnt), 64'(c0));

        check("txn_queue_empty", 64'(txn_q.size()), 0);
        check("latency_queue_empty", 64'(lat_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
